// File: rtl/wb_pkg.sv
// Shared widths, FSM encoding and bus record types for the two-master Wishbone arbiter.
// OWN state encodings are deliberately one-hot so they double as the grant vector.
package wb_pkg;

  localparam int ADR_W           = 16;
  localparam int DAT_W           = 8;
  localparam int WDOG_W          = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OWN_M0 = 2'b01,
    ST_OWN_M1 = 2'b10
  } arb_state_t;

  // One master's request-side signals, bundled so the slave mux is a single select.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic             cyc;
    logic             stb;
    logic             we;
  } wb_req_t;

  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      ST_OWN_M0: return 2'b01;
      ST_OWN_M1: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive strobed-but-unacked cycles and flags expiry on the
// cycle the count reaches TIMEOUT_CYCLES-1; an ack in that same cycle suppresses expiry.
module wb_arb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_count;

  assign expired = stb & ~ack & (r_count == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr || !stb || ack || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter with alternating tie-break, one IDLE cycle between grants,
// a purely combinational data path and a stall watchdog that aborts hung strobes.
module wb_arbiter_2
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  // master 0
  input  logic [ADR_W-1:0] m0_wb_adr_i,
  input  logic [DAT_W-1:0] m0_wb_dat_i,
  output logic [DAT_W-1:0] m0_wb_dat_o,
  input  logic             m0_wb_cyc_i,
  input  logic             m0_wb_stb_i,
  input  logic             m0_wb_we_i,
  output logic             m0_wb_ack_o,
  output logic             m0_wb_err_o,
  // master 1
  input  logic [ADR_W-1:0] m1_wb_adr_i,
  input  logic [DAT_W-1:0] m1_wb_dat_i,
  output logic [DAT_W-1:0] m1_wb_dat_o,
  input  logic             m1_wb_cyc_i,
  input  logic             m1_wb_stb_i,
  input  logic             m1_wb_we_i,
  output logic             m1_wb_ack_o,
  output logic             m1_wb_err_o,
  // shared slave side
  output logic [ADR_W-1:0] s_wb_adr_o,
  output logic [DAT_W-1:0] s_wb_dat_o,
  input  logic [DAT_W-1:0] s_wb_dat_i,
  output logic             s_wb_cyc_o,
  output logic             s_wb_stb_o,
  output logic             s_wb_we_o,
  input  logic             s_wb_ack_i,
  // status
  output logic [1:0]       grant_o,
  output logic             timeout_o,
  output arb_state_t       o_dbg_state
);

  // Handshake: a master's transfer completes in the cycle where its stb=1 and the
  // slave's ack=1 while it owns the bus; err ends it instead when the watchdog expires.
  // A master that does not own the bus sees ack=0/err=0 and is simply stalled.

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_grant;   // 0 = m0 granted last, 1 = m1 granted last
  logic       r_timeout;

  wb_req_t    w_m0_req;
  wb_req_t    w_m1_req;
  wb_req_t    w_sel_req;
  logic       w_own_m0;
  logic       w_own_m1;
  logic       w_state_chg;
  logic       w_expired;

  assign w_m0_req = '{adr: m0_wb_adr_i, dat: m0_wb_dat_i, cyc: m0_wb_cyc_i,
                      stb: m0_wb_stb_i, we: m0_wb_we_i};
  assign w_m1_req = '{adr: m1_wb_adr_i, dat: m1_wb_dat_i, cyc: m1_wb_cyc_i,
                      stb: m1_wb_stb_i, we: m1_wb_we_i};

  assign w_own_m0    = (r_state == ST_OWN_M0);
  assign w_own_m1    = (r_state == ST_OWN_M1);
  assign w_state_chg = (r_state != w_next_state);

  // Unforced strobe feeds the watchdog so the stb override cannot loop back into it.
  assign w_sel_req = w_own_m0 ? w_m0_req :
                     w_own_m1 ? w_m1_req : '0;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stb     (w_sel_req.stb),
    .ack     (s_wb_ack_i),
    .clr     (w_state_chg),
    .expired (w_expired)
  );

  // State register, tie-break memory and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_next_state == ST_OWN_M0) begin
        r_last_grant <= 1'b0;
      end else if (r_state == ST_IDLE && w_next_state == ST_OWN_M1) begin
        r_last_grant <= 1'b1;
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Owners only ever fall back to IDLE, which enforces the gap cycle between grants.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          w_next_state = r_last_grant ? ST_OWN_M0 : ST_OWN_M1;
        end else if (m0_wb_cyc_i) begin
          w_next_state = ST_OWN_M0;
        end else if (m1_wb_cyc_i) begin
          w_next_state = ST_OWN_M1;
        end
      end
      ST_OWN_M0: begin
        if (!m0_wb_cyc_i) w_next_state = ST_IDLE;
      end
      ST_OWN_M1: begin
        if (!m1_wb_cyc_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    s_wb_adr_o  = w_sel_req.adr;
    s_wb_dat_o  = w_sel_req.dat;
    s_wb_cyc_o  = w_sel_req.cyc;
    s_wb_stb_o  = w_sel_req.stb & ~w_expired;
    s_wb_we_o   = w_sel_req.we;

    m0_wb_ack_o = w_own_m0 & s_wb_ack_i & m0_wb_stb_i;
    m0_wb_err_o = w_own_m0 & w_expired;
    m0_wb_dat_o = w_own_m0 ? s_wb_dat_i : '0;

    m1_wb_ack_o = w_own_m1 & s_wb_ack_i & m1_wb_stb_i;
    m1_wb_err_o = w_own_m1 & w_expired;
    m1_wb_dat_o = w_own_m1 ? s_wb_dat_i : '0;

    grant_o     = grant_of(r_state);
    timeout_o   = r_timeout;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Directed bench for wb_arbiter_2 (TIMEOUT_CYCLES=4): a per-cycle vector table with
// hand-computed expectations, then hand-written latency and watchdog sequences.
module tb_wb_arbiter_2;
  import wb_pkg::*;

  localparam logic [7:0] M0_DAT = 8'h5A;
  localparam logic [7:0] M1_DAT = 8'hC3;
  localparam logic [7:0] S_DAT  = 8'h99;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_wb_adr_i, m1_wb_adr_i, s_wb_adr_o;
  logic [7:0]  m0_wb_dat_i, m0_wb_dat_o, m1_wb_dat_i, m1_wb_dat_o;
  logic [7:0]  s_wb_dat_o, s_wb_dat_i;
  logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_ack_o, m0_wb_err_o;
  logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_ack_o, m1_wb_err_o;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;
  arb_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  wb_arbiter_2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_dat_o(m0_wb_dat_o),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_dat_o(m1_wb_dat_o),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_ack_i(s_wb_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .o_dbg_state(dbg_state)
  );

  typedef struct {
    bit          rst_n;
    bit          c0, s0, w0;
    logic [15:0] a0;
    bit          c1, s1;
    logic [15:0] a1;
    bit          ack;
    logic [1:0]  g;
    bit          scyc, sstb;
    logic [15:0] sadr;
    bit          k0, e0, k1, e1, tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rst_n, bit c0, bit s0, bit w0, logic [15:0] a0,
                             bit c1, bit s1, logic [15:0] a1, bit ack,
                             logic [1:0] g, bit scyc, bit sstb, logic [15:0] sadr,
                             bit k0, bit e0, bit k1, bit e1, bit tmo);
    vec_t t;
    t.rst_n = rst_n; t.c0 = c0; t.s0 = s0; t.w0 = w0; t.a0 = a0;
    t.c1 = c1; t.s1 = s1; t.a1 = a1; t.ack = ack;
    t.g = g; t.scyc = scyc; t.sstb = sstb; t.sadr = sadr;
    t.k0 = k0; t.e0 = e0; t.k1 = k1; t.e1 = e1; t.tmo = tmo;
    return t;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d act=%h exp=%h", name, cur, act, exp);
    end
  endtask

  // driver: inputs right after the edge, outputs sampled 1 ns later
  task automatic run_vec(input vec_t t);
    @(posedge clk); #1;
    rst         = t.rst_n;
    m0_wb_cyc_i = t.c0; m0_wb_stb_i = t.s0; m0_wb_we_i = t.w0; m0_wb_adr_i = t.a0;
    m1_wb_cyc_i = t.c1; m1_wb_stb_i = t.s1; m1_wb_adr_i = t.a1;
    s_wb_ack_i  = t.ack;
    #1;
    chk("grant",    16'(grant_o),    16'(t.g));
    chk("s_cyc",    16'(s_wb_cyc_o), 16'(t.scyc));
    chk("s_stb",    16'(s_wb_stb_o), 16'(t.sstb));
    chk("s_adr",    s_wb_adr_o,      t.sadr);
    chk("s_we",     16'(s_wb_we_o),  (t.g == 2'b01) ? 16'(t.w0) : 16'h0);
    chk("s_dat",    16'(s_wb_dat_o), (t.g == 2'b01) ? 16'(M0_DAT) :
                                     (t.g == 2'b10) ? 16'(M1_DAT) : 16'h0);
    chk("m0_ack",   16'(m0_wb_ack_o), 16'(t.k0));
    chk("m0_err",   16'(m0_wb_err_o), 16'(t.e0));
    chk("m0_dat",   16'(m0_wb_dat_o), (t.g == 2'b01) ? 16'(S_DAT) : 16'h0);
    chk("m1_ack",   16'(m1_wb_ack_o), 16'(t.k1));
    chk("m1_err",   16'(m1_wb_err_o), 16'(t.e1));
    chk("m1_dat",   16'(m1_wb_dat_o), (t.g == 2'b10) ? 16'(S_DAT) : 16'h0);
    chk("timeout",  16'(timeout_o),   16'(t.tmo));
  endtask

  task automatic idle_rows(input int n, input bit tmo);
    for (int i = 0; i < n; i++)
      vecs.push_back(v(1, 0,0,0,16'h0, 0,0,16'h0, 0, 2'b00,0,0,16'h0, 0,0,0,0, tmo));
  endtask

  int  lat, n;
  bit  got;

  initial begin
    rst = 1'b0;
    m0_wb_adr_i = '0; m0_wb_dat_i = M0_DAT; m0_wb_cyc_i = 0; m0_wb_stb_i = 0; m0_wb_we_i = 0;
    m1_wb_adr_i = '0; m1_wb_dat_i = M1_DAT; m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0;
    s_wb_dat_i = S_DAT; s_wb_ack_i = 0;
    @(posedge clk);

    // reset state
    vecs.push_back(v(0, 0,0,0,16'h0, 0,0,16'h0, 0, 2'b00,0,0,16'h0, 0,0,0,0, 0));

    // simultaneous requests, three rounds each; owner drops cyc in its ack cycle
    for (int k = 0; k < 3; k++) begin
      bit more;
      more = (k < 2);
      vecs.push_back(v(1, 1,1,1,16'h0A00, 1,1,16'h0B00, 0, 2'b00,0,0,16'h0, 0,0,0,0, 0));
      vecs.push_back(v(1, 0,1,1,16'h0A00, 1,1,16'h0B00, 1, 2'b01,0,1,16'h0A00, 1,0,0,0, 0));
      vecs.push_back(v(1, more,more,1,more ? 16'h0A00 : 16'h0, 1,1,16'h0B00, 0,
                       2'b00,0,0,16'h0, 0,0,0,0, 0));
      vecs.push_back(v(1, more,more,1,more ? 16'h0A00 : 16'h0, 0,1,16'h0B00, 1,
                       2'b10,0,1,16'h0B00, 0,0,1,0, 0));
    end
    idle_rows(1, 0);

    // m0 single write, slave acks after two wait cycles
    vecs.push_back(v(1, 1,1,1,16'h8000, 0,0,16'h0, 0, 2'b00,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,1,16'h8000, 0,0,16'h0, 0, 2'b01,1,1,16'h8000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,1,16'h8000, 0,0,16'h0, 0, 2'b01,1,1,16'h8000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,1,16'h8000, 0,0,16'h0, 1, 2'b01,1,1,16'h8000, 1,0,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    0,0,16'h0, 0, 2'b01,0,0,16'h0,    0,0,0,0, 0));
    idle_rows(1, 0);

    // m1 owns, m0 requests mid-transfer and waits
    vecs.push_back(v(1, 0,0,0,16'h0,    1,1,16'h1234, 0, 2'b00,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    1,1,16'h1234, 0, 2'b10,1,1,16'h1234, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h4000, 1,1,16'h1234, 0, 2'b10,1,1,16'h1234, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h4000, 1,1,16'h1234, 1, 2'b10,1,1,16'h1234, 0,0,1,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h4000, 0,0,16'h0,    0, 2'b10,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h4000, 0,0,16'h0,    0, 2'b00,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h4000, 0,0,16'h0,    1, 2'b01,1,1,16'h4000, 1,0,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    0,0,16'h0,    0, 2'b01,0,0,16'h0,    0,0,0,0, 0));
    idle_rows(1, 0);

    // slave never acks: err on 4th stalled cycle, stb forced low, sticky timeout
    vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 0, 2'b00,0,0,16'h0, 0,0,0,0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 0, 2'b01,1,1,16'h2000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 0, 2'b01,1,0,16'h2000, 0,1,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    0,0,16'h0, 0, 2'b01,0,0,16'h0,    0,0,0,0, 1));
    idle_rows(2, 1);
    vecs.push_back(v(0, 0,0,0,16'h0, 0,0,16'h0, 0, 2'b00,0,0,16'h0, 0,0,0,0, 1));

    // ack lands exactly on the timeout cycle: ack wins
    vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 0, 2'b00,0,0,16'h0, 0,0,0,0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 0, 2'b01,1,1,16'h2000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h2000, 0,0,16'h0, 1, 2'b01,1,1,16'h2000, 1,0,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    0,0,16'h0, 0, 2'b01,0,0,16'h0,    0,0,0,0, 0));
    idle_rows(1, 0);

    // reset during a stalled m0 read aborts it
    vecs.push_back(v(1, 1,1,0,16'h3000, 0,0,16'h0, 0, 2'b00,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h3000, 0,0,16'h0, 0, 2'b01,1,1,16'h3000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h3000, 0,0,16'h0, 0, 2'b01,1,1,16'h3000, 0,0,0,0, 0));
    vecs.push_back(v(0, 1,1,0,16'h3000, 0,0,16'h0, 0, 2'b01,1,1,16'h3000, 0,0,0,0, 0));
    vecs.push_back(v(1, 1,1,0,16'h3000, 0,0,16'h0, 0, 2'b00,0,0,16'h0,    0,0,0,0, 0));
    vecs.push_back(v(1, 0,0,0,16'h0,    0,0,16'h0, 0, 2'b01,0,0,16'h0,    0,0,0,0, 0));
    idle_rows(1, 0);

    foreach (vecs[i]) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // hand-written: uncontested grant latency for m1, measured with a bounded wait
    cur = -1;
    @(posedge clk); #1;
    m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 1; m1_wb_adr_i = 16'h7777;
    s_wb_ack_i = 0;
    #1;
    chk("tmo_before", 16'(timeout_o), 16'h0);
    got = 0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_wb_cyc_o === 1'b1) begin
        got = 1; lat = i; break;
      end
      @(posedge clk); #2;
    end
    chk("grant_latency", got ? 16'(lat) : 16'hFFFF, 16'd1);
    chk("m1_s_we", 16'(s_wb_we_o), 16'h1);

    // hand-written: stalled strobe cycles until err, bounded
    got = 0; n = 1;
    for (int i = 0; i < 20; i++) begin
      if (m1_wb_err_o === 1'b1) begin
        got = 1; break;
      end
      @(posedge clk); #2;
      n++;
    end
    chk("stall_to_err", got ? 16'(n) : 16'hFFFF, 16'd4);
    chk("err_stb_low", 16'(s_wb_stb_o), 16'h0);
    chk("err_grant", 16'(grant_o), 16'h2);
    chk("err_m0_quiet", 16'(m0_wb_err_o), 16'h0);
    @(posedge clk); #2;
    chk("err_one_cycle", 16'(m1_wb_err_o), 16'h0);
    chk("tmo_set", 16'(timeout_o), 16'h1);
    chk("stb_restored", 16'(s_wb_stb_o), 16'h1);
    @(posedge clk); #1;
    m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0; m1_wb_adr_i = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("tmo_sticky", 16'(timeout_o), 16'h1);
      chk("idle_grant", 16'(grant_o), 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
